// File: rtl/sys_defs.sv
// Shared definitions for the pipelined ALU/branch functional unit.
package sys_defs;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluAnd    = 5'd2,
    AluOr     = 5'd3,
    AluXor    = 5'd4,
    AluSlt    = 5'd5,
    AluSltu   = 5'd6,
    AluSll    = 5'd7,
    AluSrl    = 5'd8,
    AluSra    = 5'd9,
    AluMul    = 5'd10,
    AluMulh   = 5'd11,
    AluMulhsu = 5'd12,
    AluMulhu  = 5'd13
  } ALU_FUNC;

  localparam logic [31:0] ALU_DEFAULT_RESULT = 32'hfacebeec;

  function automatic logic is_mul_func(ALU_FUNC f);
    return f inside {AluMul, AluMulh, AluMulhsu, AluMulhu};
  endfunction

endpackage

// File: rtl/fu_alu_compute.sv
// Combinational ALU and branch-condition evaluation at the head of the pipe.
// Multiply funcs fall through to the default result; the pipe overrides them when enabled.
module fu_alu_compute
  import sys_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  ALU_FUNC         func,
  input  logic [2:0]      br_func,
  input  logic            cond_branch,
  input  logic            uncond_branch,
  output logic [XLEN-1:0] result,
  output logic            take_branch
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [ShW-1:0] shamt;
  logic           cond;

  assign shamt = opb[ShW-1:0];

  always_comb begin
    result = XLEN'(ALU_DEFAULT_RESULT);
    case (func)
      AluAdd:  result = opa + opb;
      AluSub:  result = opa - opb;
      AluAnd:  result = opa & opb;
      AluOr:   result = opa | opb;
      AluXor:  result = opa ^ opb;
      AluSlt:  result = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      AluSltu: result = {{(XLEN-1){1'b0}}, opa < opb};
      AluSll:  result = opa << shamt;
      AluSrl:  result = opa >> shamt;
      AluSra:  result = $unsigned($signed(opa) >>> shamt);
      default: ;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (br_func)
      3'b000:  cond = (rs1 == rs2);
      3'b001:  cond = (rs1 != rs2);
      3'b100:  cond = ($signed(rs1) < $signed(rs2));
      3'b101:  cond = ($signed(rs1) >= $signed(rs2));
      3'b110:  cond = (rs1 < rs2);
      3'b111:  cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

  assign take_branch = uncond_branch | (cond_branch & cond);

endmodule

// File: rtl/fu_alu_pipe.sv
// Elastic, fixed-latency ALU/branch functional unit with squash and per-op tag.
// Define FU_ALU_MUL_EN to add MUL/MULH/MULHSU/MULHU (multiply finishes in stage 1).
module fu_alu_pipe
  import sys_defs::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  ALU_FUNC          in_func,
  input  logic [2:0]       in_br_func,
  input  logic             in_cond_branch,
  input  logic             in_uncond_branch,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             squash,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_take_branch,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  result;
    logic             take_branch;
    logic [TAG_W-1:0] tag;
  } FU_ALU_STAGE_PACKET;

  if (XLEN < 8) begin : g_bad_xlen
    $error("fu_alu_pipe: XLEN must be at least 8");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("fu_alu_pipe: STAGES must be in 1..8");
  end

  FU_ALU_STAGE_PACKET stage_q [STAGES];
  FU_ALU_STAGE_PACKET src     [STAGES];
  logic [STAGES-1:0]  rdy;
  logic [XLEN-1:0]    comp_result;
  logic               comp_take;
  logic               accept;

  fu_alu_compute #(
    .XLEN (XLEN)
  ) u_compute (
    .opa           (in_opa),
    .opb           (in_opb),
    .rs1           (in_rs1),
    .rs2           (in_rs2),
    .func          (in_func),
    .br_func       (in_br_func),
    .cond_branch   (in_cond_branch),
    .uncond_branch (in_uncond_branch),
    .result        (comp_result),
    .take_branch   (comp_take)
  );

  // A stage is ready when it or any stage downstream of it has room.
  always_comb begin
    logic room;
    room = out_ready;
    rdy  = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      room   = room || !stage_q[i].valid;
      rdy[i] = room;
    end
  end

  assign in_ready = rdy[0];
  assign accept   = in_valid && rdy[0] && !squash;

`ifdef FU_ALU_MUL_EN
  if (STAGES < 2) begin : g_bad_mul_stages
    $error("fu_alu_pipe: FU_ALU_MUL_EN needs STAGES >= 2");
  end

  logic            mul_q;
  logic            mul_hi_q;
  logic [XLEN:0]   mul_a_q;
  logic [XLEN:0]   mul_b_q;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] mul_prod;

  // Operands carry an explicit sign bit so one unsigned multiplier covers all signedness mixes.
  always_ff @(posedge clock) begin
    if (reset) begin
      mul_q    <= 1'b0;
      mul_hi_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else if (accept) begin
      mul_q    <= is_mul_func(in_func);
      mul_hi_q <= (in_func != AluMul);
      mul_a_q  <= {(in_func inside {AluMulh, AluMulhsu}) & in_opa[XLEN-1], in_opa};
      mul_b_q  <= {(in_func == AluMulh) & in_opb[XLEN-1], in_opb};
    end
  end

  assign mul_a_ext = {{(XLEN-1){mul_a_q[XLEN]}}, mul_a_q};
  assign mul_b_ext = {{(XLEN-1){mul_b_q[XLEN]}}, mul_b_q};
  assign mul_prod  = mul_a_ext * mul_b_ext;
`endif

  always_comb begin
    src[0].valid       = accept;
    src[0].result      = comp_result;
    src[0].take_branch = comp_take;
    src[0].tag         = in_tag;
    for (int i = 1; i < int'(STAGES); i++) begin
      src[i] = stage_q[i-1];
    end
`ifdef FU_ALU_MUL_EN
    if (mul_q) begin
      src[1].result = mul_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
    end
`endif
  end

  // Payload only moves with a valid op so idle outputs keep their last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (squash) begin
          stage_q[i].valid <= 1'b0;
        end else if (rdy[i]) begin
          stage_q[i].valid <= src[i].valid;
          if (src[i].valid) begin
            stage_q[i].result      <= src[i].result;
            stage_q[i].take_branch <= src[i].take_branch;
            stage_q[i].tag         <= src[i].tag;
          end
        end
      end
    end
  end

  assign out_valid       = stage_q[STAGES-1].valid;
  assign out_result      = stage_q[STAGES-1].result;
  assign out_take_branch = stage_q[STAGES-1].take_branch;
  assign out_tag         = stage_q[STAGES-1].tag;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Self-checking bench for fu_alu_pipe (XLEN=32, STAGES=2, TAG_W=6): directed vectors plus a
// reference model checked on every output handshake.
module tb_fu_alu_pipe;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_opa, in_opb, in_rs1, in_rs2;
  ALU_FUNC     in_func;
  logic [2:0]  in_br_func;
  logic        in_cond_branch, in_uncond_branch;
  logic [5:0]  in_tag;
  logic        squash;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_take_branch;
  logic [5:0]  out_tag;

  fu_alu_pipe #(
    .XLEN   (32),
    .STAGES (2),
    .TAG_W  (6)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_opa           (in_opa),
    .in_opb           (in_opb),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_func          (in_func),
    .in_br_func       (in_br_func),
    .in_cond_branch   (in_cond_branch),
    .in_uncond_branch (in_uncond_branch),
    .in_tag           (in_tag),
    .squash           (squash),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_take_branch  (out_take_branch),
    .out_tag          (out_tag)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    ALU_FUNC     f;
    logic [31:0] a, b, r1, r2;
    logic [2:0]  bf;
    logic        cb, ub;
    logic [5:0]  tag;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic        take;
    logic [5:0]  tag;
  } res_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] exp;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   got_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: ALU and branch rules in plain arithmetic.
  function automatic res_t model(input op_t o);
    res_t        r;
    logic        c;
    logic [63:0] p;
    r.tag = o.tag;
    p     = '0;
    case (o.f)
      AluAdd:  r.res = o.a + o.b;
      AluSub:  r.res = o.a - o.b;
      AluAnd:  r.res = o.a & o.b;
      AluOr:   r.res = o.a | o.b;
      AluXor:  r.res = o.a ^ o.b;
      AluSlt:  r.res = ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
      AluSltu: r.res = (o.a < o.b) ? 32'd1 : 32'd0;
      AluSll:  r.res = o.a << o.b[4:0];
      AluSrl:  r.res = o.a >> o.b[4:0];
      AluSra:  r.res = $unsigned($signed(o.a) >>> o.b[4:0]);
`ifdef FU_ALU_MUL_EN
      AluMul:  r.res = o.a * o.b;
      AluMulh: begin
        p = {{32{o.a[31]}}, o.a} * {{32{o.b[31]}}, o.b};
        r.res = p[63:32];
      end
      AluMulhsu: begin
        p = {{32{o.a[31]}}, o.a} * {32'd0, o.b};
        r.res = p[63:32];
      end
      AluMulhu: begin
        p = {32'd0, o.a} * {32'd0, o.b};
        r.res = p[63:32];
      end
`endif
      default: r.res = 32'hfacebeec;
    endcase
    case (o.bf)
      3'b000:  c = (o.r1 == o.r2);
      3'b001:  c = (o.r1 != o.r2);
      3'b100:  c = ($signed(o.r1) < $signed(o.r2));
      3'b101:  c = ($signed(o.r1) >= $signed(o.r2));
      3'b110:  c = (o.r1 < o.r2);
      3'b111:  c = (o.r1 >= o.r2);
      default: c = 1'b0;
    endcase
    r.take = o.ub || (o.cb && c);
    return r;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  logic prev_stall  = 1'b0;
  logic prev_squash = 1'b0;
  res_t prev_out;
  always @(negedge clock) begin
    op_t  o;
    res_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      prev_stall  = 1'b0;
      prev_squash = 1'b0;
    end else begin
      if (prev_squash) check("valid_after_squash", out_valid, 0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_result, out_take_branch, out_tag}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("model_result", out_result, e.res);
          check("model_take", out_take_branch, e.take);
          check("model_tag", out_tag, e.tag);
        end
        got_q.push_back({out_result, out_take_branch, out_tag});
        got_cyc.push_back(cyc);
      end
      prev_stall  = out_valid && !out_ready && !squash;
      prev_out    = {out_result, out_take_branch, out_tag};
      prev_squash = squash;
      if (squash) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        o = '{f: in_func, a: in_opa, b: in_opb, r1: in_rs1, r2: in_rs2, bf: in_br_func,
              cb: in_cond_branch, ub: in_uncond_branch, tag: in_tag};
        exp_q.push_back(model(o));
      end
    end
  end

  function automatic op_t alu(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] tag);
    return '{f: f, a: a, b: b, r1: 32'd0, r2: 32'd0, bf: 3'b010, cb: 1'b0, ub: 1'b0, tag: tag};
  endfunction

  function automatic op_t brop(input logic [2:0] bf, input logic [31:0] r1, input logic [31:0] r2,
                               input logic cb, input logic ub, input logic [5:0] tag);
    return '{f: AluAdd, a: 32'd4, b: 32'd8, r1: r1, r2: r2, bf: bf, cb: cb, ub: ub, tag: tag};
  endfunction

  task automatic drive(input op_t o);
    in_valid         = 1'b1;
    in_func          = o.f;
    in_opa           = o.a;
    in_opb           = o.b;
    in_rs1           = o.r1;
    in_rs2           = o.r2;
    in_br_func       = o.bf;
    in_cond_branch   = o.cb;
    in_uncond_branch = o.ub;
    in_tag           = o.tag;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   base;
    logic acc;
    int   w;
    logic [4:0] fb;

    reset = 1'b1; squash = 1'b0; out_ready = 1'b1;
    drive(alu(AluAdd, 0, 0, 0));
    in_valid = 1'b0;

    // Reset state
    step(); step();
    @(negedge clock);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    check("reset_out_take", out_take_branch, 0);
    check("reset_out_tag", out_tag, 0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("in_ready_after_reset", in_ready, 1);

    // Single ADD, latency of two cycles
    step();
    drive(alu(AluAdd, 32'd5, 32'd7, 6'd3));
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("latency_not_early", out_valid, 0);
    step();
    @(negedge clock);
    check("latency_valid", out_valid, 1);
    check("add_result", out_result, 12);
    check("add_tag", out_tag, 3);
    drain();

    // Back-to-back directed vectors
    vecs.push_back('{op: alu(AluSub, 32'd0, 32'd1, 6'd0), exp: 32'hffffffff});
    vecs.push_back('{op: alu(AluSra, 32'h80000000, 32'd4, 6'd1), exp: 32'hf8000000});
    vecs.push_back('{op: alu(AluSltu, 32'd1, 32'd2, 6'd2), exp: 32'd1});
    vecs.push_back('{op: alu(AluAnd, 32'hf0f0f0f0, 32'h0ff00ff0, 6'd3), exp: 32'h00f000f0});
    vecs.push_back('{op: alu(AluOr, 32'h00000f00, 32'h000000f0, 6'd4), exp: 32'h00000ff0});
    vecs.push_back('{op: alu(AluXor, 32'hffff0000, 32'h0f0f0f0f, 6'd5), exp: 32'hf0f00f0f});
    vecs.push_back('{op: alu(AluSlt, 32'hffffffff, 32'd1, 6'd6), exp: 32'd1});
    vecs.push_back('{op: alu(AluSltu, 32'hffffffff, 32'd1, 6'd7), exp: 32'd0});
    vecs.push_back('{op: alu(AluSll, 32'd1, 32'd35, 6'd8), exp: 32'd8});
    vecs.push_back('{op: alu(AluSrl, 32'h80000000, 32'd31, 6'd9), exp: 32'd1});
    vecs.push_back('{op: alu(AluAdd, 32'hffffffff, 32'd2, 6'd10), exp: 32'd1});
    vecs.push_back('{op: alu(ALU_FUNC'(5'd31), 32'd1, 32'd1, 6'd11), exp: 32'hfacebeec});
`ifdef FU_ALU_MUL_EN
    vecs.push_back('{op: alu(AluMulh, 32'h80000000, 32'h80000000, 6'd12), exp: 32'h40000000});
    vecs.push_back('{op: alu(AluMulhu, 32'hffffffff, 32'd2, 6'd13), exp: 32'd1});
    vecs.push_back('{op: alu(AluMulhsu, 32'hffffffff, 32'd2, 6'd14), exp: 32'hffffffff});
    vecs.push_back('{op: alu(AluMul, 32'd3, 32'd4, 6'd15), exp: 32'd12});
`else
    vecs.push_back('{op: alu(AluMul, 32'd3, 32'd4, 6'd12), exp: 32'hfacebeec});
    vecs.push_back('{op: alu(AluMulhu, 32'hffffffff, 32'd2, 6'd13), exp: 32'hfacebeec});
`endif
    base = got_q.size();
    step();
    foreach (vecs[k]) begin
      drive(vecs[k].op);
      step();
    end
    in_valid = 1'b0;
    drain();
    foreach (vecs[k]) begin
      check("vec_result", got_q[base+k].res, vecs[k].exp);
      check("vec_tag", got_q[base+k].tag, vecs[k].op.tag);
      if (k > 0) check("vec_throughput", got_cyc[base+k] - got_cyc[base+k-1], 1);
    end

    // Branch conditions
    base = got_q.size();
    step();
    drive(brop(3'b100, 32'hffffffff, 32'd1, 1'b1, 1'b0, 6'd20)); step();
    drive(brop(3'b110, 32'hffffffff, 32'd1, 1'b1, 1'b0, 6'd21)); step();
    drive(brop(3'b000, 32'd5, 32'd9, 1'b0, 1'b1, 6'd22)); step();
    drive(brop(3'b000, 32'd5, 32'd5, 1'b1, 1'b0, 6'd23)); step();
    drive(brop(3'b010, 32'd5, 32'd5, 1'b1, 1'b0, 6'd24)); step();
    drive(brop(3'b101, 32'd5, 32'd5, 1'b0, 1'b0, 6'd25)); step();
    in_valid = 1'b0;
    drain();
    check("blt_take", got_q[base].take, 1);
    check("bltu_take", got_q[base+1].take, 0);
    check("jump_take", got_q[base+2].take, 1);
    check("beq_take", got_q[base+3].take, 1);
    check("br010_take", got_q[base+4].take, 0);
    check("notbranch_take", got_q[base+5].take, 0);
    check("branch_alu_result", got_q[base].res, 12);

    // Backpressure: two ops fill the pipe, third waits
    base = got_q.size();
    step();
    out_ready = 1'b0;
    drive(alu(AluAdd, 32'd1, 32'd1, 6'd1)); step();
    drive(alu(AluAdd, 32'd2, 32'd2, 6'd2)); step();
    drive(alu(AluAdd, 32'd3, 32'd3, 6'd3));
    @(negedge clock);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_result", out_result, 2);
    step(); step();
    @(negedge clock);
    check("bp_still_held", out_result, 2);
    check("bp_in_ready_still_low", in_ready, 0);
    step();
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_in_ready_release", in_ready, 1);
    step();
    in_valid = 1'b0;
    drain();
    check("bp_count", got_q.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      check("bp_order_result", got_q[base+k].res, 2 * (k + 1));
      check("bp_order_tag", got_q[base+k].tag, k + 1);
      if (k > 0) check("bp_back_to_back", got_cyc[base+k] - got_cyc[base+k-1], 1);
    end

    // Squash: A delivered in the squash cycle, B killed, C dropped
    base = got_q.size();
    step();
    drive(alu(AluAdd, 32'd10, 32'd1, 6'd30)); step();
    drive(alu(AluAdd, 32'd20, 32'd1, 6'd31)); step();
    drive(alu(AluAdd, 32'd30, 32'd1, 6'd32));
    squash = 1'b1;
    @(negedge clock);
    check("squash_in_ready", in_ready, 1);
    step();
    squash = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("squash_next_invalid", out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("squash_no_stale", out_valid, 0);
    end
    check("squash_delivered", got_q.size() - base, 1);
    check("squash_delivered_tag", got_q[base].tag, 30);
    check("squash_retained_result", out_result, 11);
    step();
    drive(alu(AluSub, 32'd9, 32'd2, 6'd9)); step();
    in_valid = 1'b0;
    drain();
    check("post_squash_result", got_q[got_q.size()-1].res, 7);

    // Reset mid-operation
    step();
    drive(alu(AluAdd, 32'd1, 32'd2, 6'd5)); step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    @(negedge clock);
    check("midreset_valid", out_valid, 0);
    check("midreset_result", out_result, 0);
    check("midreset_tag", out_tag, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("midreset_no_stale", out_valid, 0);
    end

    // Stream with random output backpressure, checked by the model
    step();
    for (int n = 0; n < 24; n++) begin
      w  = $urandom_range(0, 14);
      fb = (w == 14) ? 5'd31 : 5'(w);
      drive('{f: ALU_FUNC'(fb), a: $urandom, b: $urandom, r1: $urandom, r2: $urandom,
              bf: 3'($urandom_range(0, 7)), cb: 1'($urandom_range(0, 1)),
              ub: 1'($urandom_range(0, 1)), tag: 6'(n)});
      w = 0;
      do begin
        @(negedge clock);
        acc = in_ready;
        step();
        out_ready = 1'($urandom_range(0, 1));
        w++;
      end while (!acc && w < 40);
      if (!acc) check("stream_accept", acc, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
